// File: rtl/conv_addr_gen_if.sv
// Control and address bus of the convolution address generator.
// The sequencer drives the counter controls; the generator returns addresses and status.
interface conv_addr_gen_if #(
   parameter int IMG_W     = 4,
   parameter int IMG_H     = 4,
   parameter int CH        = 2,
   parameter int K         = 3,
   parameter int N_FILTERS = 2
);
   localparam int OW     = IMG_W - K + 1;
   localparam int OH     = IMG_H - K + 1;
   localparam int TAPS   = K * K * CH;
   localparam int IMG_AW = $clog2(IMG_W * IMG_H * CH);
   localparam int WGT_AW = $clog2(N_FILTERS * TAPS);
   localparam int OUT_AW = $clog2(N_FILTERS * OW * OH);

   logic              rst_cnt_window;
   logic              rst_cnt_col;
   logic              rst_cnt_row;
   logic              cen_cnt_window;
   logic              sel;
   logic [IMG_AW-1:0] img_addr;
   logic [WGT_AW-1:0] wgt_addr;
   logic              addr_valid;
   logic [OUT_AW-1:0] out_addr;
   logic              out_we;
   logic              one_window_done;
   logic              one_row_done;
   logic              done_row;

   modport master (
      output rst_cnt_window, rst_cnt_col, rst_cnt_row, cen_cnt_window, sel,
      input  img_addr, wgt_addr, addr_valid, out_addr, out_we,
             one_window_done, one_row_done, done_row
   );

   modport slave (
      input  rst_cnt_window, rst_cnt_col, rst_cnt_row, cen_cnt_window, sel,
      output img_addr, wgt_addr, addr_valid, out_addr, out_we,
             one_window_done, one_row_done, done_row
   );
endinterface

// File: rtl/conv_addr_gen.sv
// Address generator for a stride-1, unpadded KxK convolution: walks one window
// tap by tap (kx fastest, then ky, then kc) and emits the result write address.
module conv_addr_gen #(
   parameter int IMG_W     = 4,
   parameter int IMG_H     = 4,
   parameter int CH        = 2,
   parameter int K         = 3,
   parameter int N_FILTERS = 2
) (
   input logic             clk,
   input logic             reset,
   conv_addr_gen_if.slave  bus
);
   localparam int OW     = IMG_W - K + 1;
   localparam int OH     = IMG_H - K + 1;
   localparam int TAPS   = K * K * CH;
   localparam int IMG_AW = $clog2(IMG_W * IMG_H * CH);
   localparam int WGT_AW = $clog2(N_FILTERS * TAPS);
   localparam int OUT_AW = $clog2(N_FILTERS * OW * OH);
   localparam int KW     = (K > 1)    ? $clog2(K)    : 1;
   localparam int CW     = (CH > 1)   ? $clog2(CH)   : 1;
   localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int COLW   = (OW > 1)   ? $clog2(OW)   : 1;
   localparam int ROWW   = (OH > 1)   ? $clog2(OH)   : 1;

   logic [KW-1:0]     kx_reg, ky_reg;
   logic [CW-1:0]     kc_reg;
   logic [TW-1:0]     t_reg;
   logic [COLW-1:0]   col_reg;
   logic [ROWW-1:0]   row_reg;
   logic              win_done_reg, win_done_prev_reg;
   logic              addr_valid_reg, out_we_reg;
   logic [IMG_AW-1:0] img_addr_reg;
   logic [WGT_AW-1:0] wgt_addr_reg;
   logic [OUT_AW-1:0] out_addr_reg;

   logic issue;
   logic col_last, row_last, win_rise;

   assign issue    = bus.cen_cnt_window && !win_done_reg && !bus.rst_cnt_window;
   assign col_last = (col_reg == COLW'(OW - 1));
   assign row_last = (row_reg == ROWW'(OH - 1));
   assign win_rise = win_done_reg && !win_done_prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         kx_reg            <= '0;
         ky_reg            <= '0;
         kc_reg            <= '0;
         t_reg             <= '0;
         col_reg           <= '0;
         row_reg           <= '0;
         win_done_reg      <= 1'b0;
         win_done_prev_reg <= 1'b0;
         addr_valid_reg    <= 1'b0;
         out_we_reg        <= 1'b0;
         img_addr_reg      <= '0;
         wgt_addr_reg      <= '0;
         out_addr_reg      <= '0;
      end else begin
         addr_valid_reg <= 1'b0;
         if (bus.rst_cnt_window) begin
            kx_reg       <= '0;
            ky_reg       <= '0;
            kc_reg       <= '0;
            t_reg        <= '0;
            win_done_reg <= 1'b0;
         end else if (issue) begin
            addr_valid_reg <= 1'b1;
            img_addr_reg   <= IMG_AW'(32'(kc_reg) * 32'(IMG_W * IMG_H)
                                      + (32'(row_reg) + 32'(ky_reg)) * 32'(IMG_W)
                                      + 32'(col_reg) + 32'(kx_reg));
            wgt_addr_reg   <= WGT_AW'(32'(bus.sel) * 32'(TAPS) + 32'(t_reg));
            // The last tap parks the counters; only rst_cnt_window re-arms them.
            if (t_reg == TW'(TAPS - 1)) begin
               win_done_reg <= 1'b1;
            end else begin
               t_reg <= t_reg + TW'(1);
               if (kx_reg == KW'(K - 1)) begin
                  kx_reg <= '0;
                  if (ky_reg == KW'(K - 1)) begin
                     ky_reg <= '0;
                     kc_reg <= kc_reg + CW'(1);
                  end else begin
                     ky_reg <= ky_reg + KW'(1);
                  end
               end else begin
                  kx_reg <= kx_reg + KW'(1);
               end
            end
         end

         win_done_prev_reg <= win_done_reg;
         out_we_reg        <= win_rise;
         if (win_rise)
            out_addr_reg <= OUT_AW'(32'(bus.sel) * 32'(OW * OH)
                                    + 32'(row_reg) * 32'(OW) + 32'(col_reg));

         if (bus.rst_cnt_col)
            col_reg <= '0;
         else if (bus.rst_cnt_window && win_done_reg && !col_last)
            col_reg <= col_reg + COLW'(1);

         if (bus.rst_cnt_row)
            row_reg <= '0;
         else if (bus.rst_cnt_col && win_done_reg && !row_last)
            row_reg <= row_reg + ROWW'(1);
      end
   end

   assign bus.img_addr        = img_addr_reg;
   assign bus.wgt_addr        = wgt_addr_reg;
   assign bus.addr_valid      = addr_valid_reg;
   assign bus.out_addr        = out_addr_reg;
   assign bus.out_we          = out_we_reg;
   assign bus.one_window_done = win_done_reg;
   assign bus.one_row_done    = col_last;
   assign bus.done_row        = row_last;
endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen: a table of window transactions (counter
// controls, filter select, expected addresses) plus hand-written corner sequences.
module tb_conv_addr_gen;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_addr_gen_if bus ();
   conv_addr_gen dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      int wnd, colr, rowr, sel;
      int ord, dr;
      int first, last, wgt, oaddr;
   } vec_t;

   vec_t vecs[8];
   int   exp_seq[18] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 16, 17, 18, 20, 21, 22, 24, 25, 26};
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulses, first_img, last_img, last_wgt, we_cnt, we_addr;
   int   img_seq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_ctrl(input int w, input int c, input int r);
      bus.rst_cnt_window = 1'(w);
      bus.rst_cnt_col    = 1'(c);
      bus.rst_cnt_row    = 1'(r);
      @(posedge clk); #1;
      bus.rst_cnt_window = 1'b0;
      bus.rst_cnt_col    = 1'b0;
      bus.rst_cnt_row    = 1'b0;
   endtask

   // Holds cen for 'cycles' clocks, then idles two more, logging every pulse.
   task automatic run_window(input int sel_v, input int cycles);
      bus.sel  = 1'(sel_v);
      pulses   = 0;
      we_cnt   = 0;
      we_addr  = -1;
      first_img = -1;
      last_img  = -1;
      last_wgt  = -1;
      img_seq.delete();
      bus.cen_cnt_window = 1'b1;
      for (int i = 0; i < cycles + 2; i++) begin
         if (i == cycles) bus.cen_cnt_window = 1'b0;
         @(posedge clk); #1;
         if (bus.addr_valid === 1'b1) begin
            if (pulses == 0) first_img = int'(bus.img_addr);
            last_img = int'(bus.img_addr);
            last_wgt = int'(bus.wgt_addr);
            img_seq.push_back(int'(bus.img_addr));
            pulses++;
         end
         if (bus.out_we === 1'b1) begin
            we_cnt++;
            we_addr = int'(bus.out_addr);
         end
      end
      bus.cen_cnt_window = 1'b0;
      $display("window sel=%0d pulses=%0d first=%0d last_img=%0d last_wgt=%0d out_we=%0d out_addr=%0d",
               sel_v, pulses, first_img, last_img, last_wgt, we_cnt, we_addr);
   endtask

   initial begin
      // wnd col row sel | ord dr | first last wgt oaddr
      vecs[0] = '{1, 0, 0, 0, 1, 0, 1, 27, 17, 1};
      vecs[1] = '{1, 1, 0, 0, 0, 1, 4, 30, 17, 2};
      vecs[2] = '{1, 0, 0, 1, 1, 1, 5, 31, 35, 7};
      vecs[3] = '{1, 0, 0, 0, 1, 1, 5, 31, 17, 3};
      vecs[4] = '{1, 1, 1, 0, 0, 0, 0, 26, 17, 0};
      vecs[5] = '{1, 1, 0, 1, 0, 1, 4, 30, 35, 6};
      vecs[6] = '{1, 1, 0, 0, 0, 1, 4, 30, 17, 2};
      vecs[7] = '{1, 0, 0, 1, 1, 1, 5, 31, 35, 7};

      reset              = 1'b1;
      bus.rst_cnt_window = 1'b0;
      bus.rst_cnt_col    = 1'b0;
      bus.rst_cnt_row    = 1'b0;
      bus.cen_cnt_window = 1'b0;
      bus.sel            = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset img_addr", 32'(bus.img_addr), 0);
      check("reset wgt_addr", 32'(bus.wgt_addr), 0);
      check("reset out_addr", 32'(bus.out_addr), 0);
      check("reset addr_valid", 32'(bus.addr_valid), 0);
      check("reset out_we", 32'(bus.out_we), 0);
      check("reset one_window_done", 32'(bus.one_window_done), 0);
      check("reset one_row_done", 32'(bus.one_row_done), 0);
      check("reset done_row", 32'(bus.done_row), 0);
      reset = 1'b0;

      // First window at origin: full address sequence.
      pulse_ctrl(1, 0, 0);
      run_window(0, 20);
      check("w0 pulses", 32'(pulses), 18);
      for (int i = 0; i < 18; i++)
         check($sformatf("w0 img[%0d]", i), (i < img_seq.size()) ? 32'(img_seq[i]) : 32'hFFFF_FFFF,
               32'(exp_seq[i]));
      check("w0 last_wgt", 32'(last_wgt), 17);
      check("w0 out_we count", 32'(we_cnt), 1);
      check("w0 out_addr", 32'(we_addr), 0);
      check("w0 one_window_done", 32'(bus.one_window_done), 1);

      for (int v = 0; v < 8; v++) begin
         pulse_ctrl(vecs[v].wnd, vecs[v].colr, vecs[v].rowr);
         check($sformatf("v%0d one_row_done", v), 32'(bus.one_row_done), 32'(vecs[v].ord));
         check($sformatf("v%0d done_row", v), 32'(bus.done_row), 32'(vecs[v].dr));
         check($sformatf("v%0d window_done cleared", v), 32'(bus.one_window_done), 0);
         run_window(vecs[v].sel, 22);
         check($sformatf("v%0d pulses", v), 32'(pulses), 18);
         check($sformatf("v%0d first_img", v), 32'(first_img), 32'(vecs[v].first));
         check($sformatf("v%0d last_img", v), 32'(last_img), 32'(vecs[v].last));
         check($sformatf("v%0d last_wgt", v), 32'(last_wgt), 32'(vecs[v].wgt));
         check($sformatf("v%0d out_we count", v), 32'(we_cnt), 1);
         check($sformatf("v%0d out_addr", v), 32'(we_addr), 32'(vecs[v].oaddr));
         check($sformatf("v%0d window_done", v), 32'(bus.one_window_done), 1);
      end

      // Reset arriving at tap 9 of a window.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      pulse_ctrl(1, 0, 0);
      bus.sel = 1'b1;
      bus.cen_cnt_window = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      check("mid tap8 img_addr", 32'(bus.img_addr), 10);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.cen_cnt_window = 1'b0;
      $display("reset applied at tap 9");
      check("mid-reset addr_valid", 32'(bus.addr_valid), 0);
      check("mid-reset img_addr", 32'(bus.img_addr), 0);
      check("mid-reset wgt_addr", 32'(bus.wgt_addr), 0);
      check("mid-reset out_addr", 32'(bus.out_addr), 0);
      check("mid-reset out_we", 32'(bus.out_we), 0);
      check("mid-reset one_window_done", 32'(bus.one_window_done), 0);
      we_cnt = 0;
      pulses = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.out_we === 1'b1) we_cnt++;
         if (bus.addr_valid === 1'b1) pulses++;
      end
      check("post-reset stray out_we", 32'(we_cnt), 0);
      check("post-reset stray addr_valid", 32'(pulses), 0);
      run_window(0, 22);
      check("restart first_img", 32'(first_img), 0);
      check("restart pulses", 32'(pulses), 18);
      check("restart out_addr", 32'(we_addr), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
